// File: rtl/mem_responder.sv
// Memory-side responder: decodes read/write strobes, waits a programmable number of
// cycles, then completes with a one-cycle rdata_valid or wr_done pulse.
module mem_responder #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              pc_on_adr,
    input  logic              ir_on_adr,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [ADDR_W-1:0] ir_addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              wr_done,
    output logic              busy,
    output logic              err
);

    localparam int unsigned Depth    = 2 ** ADDR_W;
    localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e state_q, state_d;

    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              wr_done_q, wr_done_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem_q [Depth];

    logic is_idle;
    logic any_strobe;
    logic req_ok;
    logic accept;
    logic reject;

    // A request is well formed only with exactly one strobe and exactly one address select.
    always_comb begin
        is_idle    = (state_q == StIdle);
        any_strobe = mem_read | mem_write;
        req_ok     = (mem_read ^ mem_write) & (pc_on_adr ^ ir_on_adr);
        accept     = is_idle & req_ok & ~ld_en;
        reject     = is_idle & any_strobe & (~req_ok | ld_en);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StWait;
            StWait:  if (cnt_q == 4'd0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        if (accept) begin
            op_wr_d = mem_write;
            addr_d  = pc_on_adr ? pc_addr : ir_addr;
            wdata_d = wdata;
            cnt_d   = WaitInit;
        end else if (state_q == StWait && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_comb begin
        rdata_valid_d = (state_q == StDone) & ~op_wr_q;
        wr_done_d     = (state_q == StDone) & op_wr_q;
        err_d         = reject;
        rdata_d       = rdata_valid_d ? mem_q[addr_q] : rdata_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_wr_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= 4'd0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            wr_done_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            op_wr_q       <= op_wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            wr_done_q     <= wr_done_d;
            err_q         <= err_d;
        end
    end

    // Array has no reset; a write still in WAIT when reset hits never reaches here.
    always_ff @(posedge clock) begin
        if (is_idle && ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end else if (state_q == StDone && op_wr_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign wr_done     = wr_done_q;
    assign err         = err_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the adding-machine controller's bus strobes.
- Accepts one read or write request per transaction, selects the address from the PC or IR source, and inserts a programmable number of wait states.
- Returns read data with a one-cycle valid pulse, or a one-cycle write-done pulse.
- Provides a side-load port for preloading program/data words before execution.

Parameters:
- ADDR_W, 4, address width; array depth is 2**ADDR_W words.
- DATA_W, 8, data word width.
- WAIT_STATES, 1, extra cycles between request acceptance and completion (0..15).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- mem_read  in  1  read request strobe
- mem_write  in  1  write request strobe
- pc_on_adr  in  1  select pc_addr as access address
- ir_on_adr  in  1  select ir_addr as access address
- pc_addr  in  ADDR_W  program-counter address
- ir_addr  in  ADDR_W  instruction-register address field
- wdata  in  DATA_W  write data (accumulator)
- ld_en  in  1  side-load write enable
- ld_addr  in  ADDR_W  side-load address
- ld_data  in  DATA_W  side-load data
- rdata  out  DATA_W  registered read data; held until next read completes
- rdata_valid  out  1  one-cycle pulse, rdata updated this cycle
- wr_done  out  1  one-cycle pulse, write committed
- busy  out  1  transaction in progress
- err  out  1  one-cycle pulse, malformed/rejected request

Behaviour:
- Reset:
  - Asynchronous to IDLE.
  - rdata=0, rdata_valid=0, wr_done=0, busy=0, err=0, wait counter=0.
  - Array contents are NOT cleared.
- States: IDLE, WAIT, DONE.
  - busy = (state != IDLE), registered.
- IDLE request decode, sampled each rising edge:
  - Valid request: exactly one of mem_read/mem_write high AND exactly one of pc_on_adr/ir_on_adr high.
  - Valid, ld_en low:
    - Latch op, address (pc_addr if pc_on_adr else ir_addr) and wdata.
    - Load counter with WAIT_STATES.
    - Go to WAIT.
  - Malformed (both strobes, or one strobe with zero or two selects): err=1 next cycle, stay IDLE, no array access.
  - No strobes: stay IDLE, err=0.
- Side load:
  - ld_en in IDLE writes ld_data to ld_addr at that edge.
  - A valid or malformed request in the same cycle is rejected: err=1, no transaction.
  - ld_en outside IDLE is ignored; no write, no err.
- WAIT:
  - Counter decrements each cycle.
  - Leaves for DONE on the edge where the counter is 0.
  - WAIT_STATES=0 goes to DONE on the next edge.
- DONE, one cycle, then IDLE unconditionally:
  - Read: rdata <= array[latched addr], rdata_valid=1.
  - Write: array[latched addr] <= latched wdata, wr_done=1.
- Latency:
  - Done pulse is high in cycle accept+WAIT_STATES+2, counting the accept edge as cycle 0.
  - WAIT_STATES=1 gives the pulse 3 cycles after acceptance.
- Strobes while busy are ignored: not queued, no err.
  - A new request is accepted in the first IDLE cycle after DONE.
- Address and data are latched at acceptance; input changes during WAIT have no effect.
- Read-after-write to the same address returns the newly written data.
- Reset mid-transaction: pending write is discarded (array unmodified); no done pulse; IDLE.
- Addresses wrap naturally within 2**ADDR_W; there is no out-of-range case.

Test Plan:
1. Reset, side-load addr 3=0x5A, then mem_read+pc_on_adr with pc_addr=3 (WAIT_STATES=1) -> busy high 3 cycles, rdata=0x5A with rdata_valid pulse 3 cycles after accept, busy low next cycle.
2. mem_write+ir_on_adr, ir_addr=7, wdata=0xC3, then read addr 7 via ir_on_adr -> wr_done pulse once, subsequent rdata=0xC3.
3. mem_read and mem_write together; then mem_read with both pc_on_adr and ir_on_adr; then mem_read with neither -> three single-cycle err pulses, busy stays 0, rdata unchanged.
4. Accept a read, then toggle mem_write and change pc_addr during WAIT -> ignored; rdata reflects the originally latched address; exactly one rdata_valid.
5. Accept a write of 0xFF to addr 2 (old value 0x11), assert reset during WAIT, then read addr 2 -> outputs zeroed on reset, no wr_done, read returns 0x11.
6. WAIT_STATES=0 build, back-to-back reads of addrs 0 and 1 -> each rdata_valid 2 cycles after its accept; second accepted the cycle after the first DONE.
